// File: rtl/mvu_requant_axi.sv
// Streaming requantization stage for the MVU/VVU AXI output stream.
// Each input beat carries PE signed accumulators for one channel fold. Per lane:
//   y = clip(round(((acc + bias[c]) * scale[c]) >> SHIFT))
// with per-channel bias/scale held in a small parameter memory.
//
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   cfg_we         - parameter word write enable
//   cfg_addr       - fold index of the parameter word to write
//   cfg_bias       - PE signed biases, lane p at [p*ACCU_WIDTH +: ACCU_WIDTH]
//   cfg_scale      - PE unsigned scales, same lane order
//   s_axis_*       - accumulator input stream (one beat per fold)
//   m_axis_*       - requantized output stream, lane p at [p*OUTPUT_WIDTH +: OUTPUT_WIDTH]
module mvu_requant_axi #(
    parameter int unsigned PE             = 1,
    parameter int unsigned MH             = 4,
    parameter int unsigned ACCU_WIDTH     = 17,
    parameter int unsigned SCALE_WIDTH    = 8,
    parameter int unsigned SHIFT          = 4,
    parameter int unsigned OUTPUT_WIDTH   = 4,
    parameter int unsigned SIGNED_OUTPUTS = 1,
    localparam int unsigned NF            = MH / PE,
    localparam int unsigned AW            = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_we,
    input  logic [AW-1:0]                   cfg_addr,
    input  logic [PE*ACCU_WIDTH-1:0]        cfg_bias,
    input  logic [PE*SCALE_WIDTH-1:0]       cfg_scale,
    input  logic [PE*ACCU_WIDTH-1:0]        s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [PE*OUTPUT_WIDTH-1:0]      m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready
);

    localparam int unsigned SW      = ACCU_WIDTH + 1;
    localparam int unsigned PW      = ACCU_WIDTH + SCALE_WIDTH + 2;
    localparam int unsigned RW      = PW + 1;
    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
    localparam logic signed [RW-1:0] OMAX = (SIGNED_OUTPUTS != 0)
                                            ? (RW'(1) << (OUTPUT_WIDTH - 1)) - RW'(1)
                                            : (RW'(1) << OUTPUT_WIDTH) - RW'(1);
    localparam logic signed [RW-1:0] OMIN = (SIGNED_OUTPUTS != 0)
                                            ? -(RW'(1) << (OUTPUT_WIDTH - 1))
                                            : '0;

    // Parameter memory: not reset, contents survive rst.
    logic [PE*ACCU_WIDTH-1:0]  bias_mem  [NF];
    logic [PE*SCALE_WIDTH-1:0] scale_mem [NF];

    logic                          en;
    logic [AW-1:0]                 nf;
    logic                          v1, v2, v3;

    logic signed [ACCU_WIDTH-1:0]  acc1   [PE];
    logic signed [ACCU_WIDTH-1:0]  bias1  [PE];
    logic [SCALE_WIDTH-1:0]        scale1 [PE];
    logic signed [SW-1:0]          sum1   [PE];
    logic signed [PW-1:0]          prod_next [PE];
    logic signed [PW-1:0]          prod2  [PE];
    logic signed [RW-1:0]          rnd    [PE];
    logic signed [RW-1:0]          clip   [PE];
    logic [PE*OUTPUT_WIDTH-1:0]    y_next;
    logic [PE*OUTPUT_WIDTH-1:0]    y3;

    // Single global enable: every stage moves together, so the output
    // register is the only place a stall has to be resolved.
    assign en            = !v3 || m_axis_tready;
    assign s_axis_tready = en;
    assign m_axis_tvalid = v3;
    assign m_axis_tdata  = y3;

    // Register write lands on the edge; S1 reads combinationally, so a read
    // on the same edge still sees the previous word.
    always_ff @(posedge clk) begin
        if (cfg_we && (32'(cfg_addr) < NF)) begin
            bias_mem[cfg_addr]  <= cfg_bias;
            scale_mem[cfg_addr] <= cfg_scale;
        end
    end

    always_comb begin
        y_next = '0;
        for (int unsigned p = 0; p < PE; p++) begin
            sum1[p]      = SW'(acc1[p]) + SW'(bias1[p]);
            prod_next[p] = PW'(sum1[p]) * PW'($signed({1'b0, scale1[p]}));
            rnd[p]       = (RW'(prod2[p]) + RND) >>> SHIFT;
            if (rnd[p] > OMAX) begin
                clip[p] = OMAX;
            end else if (rnd[p] < OMIN) begin
                clip[p] = OMIN;
            end else begin
                clip[p] = rnd[p];
            end
            y_next[p*OUTPUT_WIDTH +: OUTPUT_WIDTH] = clip[p][OUTPUT_WIDTH-1:0];
        end
    end

    // Control: valids, fold counter, output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            nf <= '0;
            y3 <= '0;
        end else if (en) begin
            v1 <= s_axis_tvalid;
            v2 <= v1;
            v3 <= v2;
            if (s_axis_tvalid) begin
                nf <= (nf == AW'(NF - 1)) ? '0 : nf + AW'(1);
            end
            // Only load on a real beat so the output holds its last value
            // through bubbles.
            if (v2) begin
                y3 <= y_next;
            end
        end
    end

    // Datapath registers: no reset needed, qualified by the valids above.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int unsigned p = 0; p < PE; p++) begin
                acc1[p]   <= s_axis_tdata[p*ACCU_WIDTH +: ACCU_WIDTH];
                bias1[p]  <= bias_mem[nf][p*ACCU_WIDTH +: ACCU_WIDTH];
                scale1[p] <= scale_mem[nf][p*SCALE_WIDTH +: SCALE_WIDTH];
                prod2[p]  <= prod_next[p];
            end
        end
    end

endmodule

// File: tb/tb_mvu_requant_axi.sv
// Self-checking bench for mvu_requant_axi with PE=2, MH=4 (NF=2),
// ACCU_WIDTH=17, SCALE_WIDTH=8, SHIFT=4, OUTPUT_WIDTH=4, signed outputs.
module tb_mvu_requant_axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [0:0]  cfg_addr;
    logic [33:0] cfg_bias;
    logic [15:0] cfg_scale;
    logic [33:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;

    mvu_requant_axi #(
        .PE             (2),
        .MH             (4),
        .ACCU_WIDTH     (17),
        .SCALE_WIDTH    (8),
        .SHIFT          (4),
        .OUTPUT_WIDTH   (4),
        .SIGNED_OUTPUTS (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_bias      (cfg_bias),
        .cfg_scale     (cfg_scale),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a0;
        int a1;
        int e0;
        int e1;
    } vec_t;

    vec_t       vecs [10];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] outq [$];
    logic [7:0] expq [$];
    int         bias_t  [2][2];
    int         scale_t [2][2];
    int         tb_nf;
    int         stall_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [3:0] lane_q(input int acc, input int bias, input int scale);
        longint p;
        longint r;
        p = longint'(acc + bias) * longint'(scale);
        r = (p + 64'sd8) >>> 4;
        if (r > 7)  r = 7;
        if (r < -8) r = -8;
        return 4'(r);
    endfunction

    function automatic logic [7:0] model(input int a0, input int a1, input int nfi);
        return {lane_q(a1, bias_t[nfi][1], scale_t[nfi][1]),
                lane_q(a0, bias_t[nfi][0], scale_t[nfi][0])};
    endfunction

    function automatic logic [7:0] pk(input int e0, input int e1);
        return {4'(e1), 4'(e0)};
    endfunction

    // Output monitor: records handshakes and checks stall behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall valid held", 32'(m_tvalid), 32'd1);
                check("stall data held", 32'(m_tdata), 32'(data_prev));
            end
            if (m_tvalid && !m_tready) begin
                stall_cnt++;
                check("ready low in stall", 32'(s_tready), 32'd0);
            end
            if (m_tvalid && m_tready) outq.push_back(m_tdata);
            stall_prev = m_tvalid && !m_tready;
            data_prev  = m_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic cfg_write(input int addr, input int b0, input int b1, input int s0, input int s1);
        cfg_we    = 1'b1;
        cfg_addr  = 1'(addr);
        cfg_bias  = {17'(b1), 17'(b0)};
        cfg_scale = {8'(s1), 8'(s0)};
        bias_t[addr][0]  = b0;
        bias_t[addr][1]  = b1;
        scale_t[addr][0] = s0;
        scale_t[addr][1] = s1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Presents a beat and returns just after the edge where it was accepted.
    task automatic send(input int a0, input int a1);
        int  n = 0;
        bit  done = 0;
        s_tvalid = 1'b1;
        s_tdata  = {17'(a1), 17'(a0)};
        while (!done && n <= 60) begin
            @(negedge clk);
            if (s_tready) done = 1;
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send timeout: got no s_axis_tready expected handshake within 60 cycles");
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        int k = 0;
        while (outq.size() < expq.size() && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (outq.size() < expq.size()) begin
            checks++;
            errors++;
            $display("FAIL %s drain: got %0d outputs expected %0d", tag, outq.size(), expq.size());
        end
        while (expq.size() > 0 && outq.size() > 0) begin
            check($sformatf("%s out%0d", tag, k), 32'(outq.pop_front()), 32'(expq.pop_front()));
            k++;
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        check($sformatf("%s extra outputs", tag), 32'(outq.size()), 32'd0);
        outq.delete();
        expq.delete();
    endtask

    task automatic run_vectors(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            expq.push_back(pk(vecs[i].e0, vecs[i].e1));
            send(vecs[i].a0, vecs[i].a1);
        end
        s_tvalid = 1'b0;
        wait_drain(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_bias  = '0;
        cfg_scale = '0;
        s_tvalid  = 1'b0;
        s_tdata   = '0;
        m_tready  = 1'b1;
        tb_nf     = 0;

        vecs[0] = '{5, -3, 5, -3};
        vecs[1] = '{100, -100, 7, -8};
        vecs[2] = '{8, 7, 1, 0};
        vecs[3] = '{-8, -9, 0, -1};
        vecs[4] = '{3, 3, 0, 3};
        vecs[5] = '{3, 3, 6, 0};
        vecs[6] = '{3, 3, 0, 3};
        vecs[7] = '{3, 3, 6, 0};
        vecs[8] = '{3, 3, 0, 3};
        vecs[9] = '{3, 3, 6, 0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset s_tready", 32'(s_tready), 32'd1);
        check("reset m_tvalid", 32'(m_tvalid), 32'd0);
        check("reset m_tdata", 32'(m_tdata), 32'd0);

        // Identity and clip, with latency check.
        cfg_write(0, 0, 0, 16, 16);
        cfg_write(1, 0, 0, 16, 16);
        expq.push_back(pk(vecs[0].e0, vecs[0].e1));
        send(vecs[0].a0, vecs[0].a1);
        expq.push_back(pk(vecs[1].e0, vecs[1].e1));
        send(vecs[1].a0, vecs[1].a1);
        check("T1 valid before latency", 32'(m_tvalid), 32'd0);
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        check("T1 valid at latency 3", 32'(m_tvalid), 32'd1);
        wait_drain("T1");

        // Rounding.
        cfg_write(0, 0, 0, 1, 1);
        cfg_write(1, 0, 0, 1, 1);
        run_vectors(2, 3, "T2");

        // Per-fold params and fold wrap.
        cfg_write(0, -3, 0, 16, 16);
        cfg_write(1, 0, 0, 32, 0);
        run_vectors(4, 9, "T3");

        // Backpressure with random beats against the model.
        cfg_write(0, 10, -20, 3, 200);
        cfg_write(1, 0, 5, 255, 1);
        tb_nf     = 0;
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int a0;
                    int a1;
                    a0 = int'($urandom_range(120)) - 60;
                    a1 = int'($urandom_range(120)) - 60;
                    expq.push_back(model(a0, a1, tb_nf));
                    tb_nf = (tb_nf + 1) % 2;
                    send(a0, a1);
                end
                s_tvalid = 1'b0;
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    if (c == 5)  m_tready = 1'b0;
                    if (c == 15) m_tready = 1'b1;
                    @(posedge clk); #1;
                end
            end
        join
        wait_drain("T4");
        check("T4 stall observed", 32'(stall_cnt > 0), 32'd1);

        // Reset mid-stream.
        send(1, 1);
        send(2, 2);
        send(3, 3);
        rst      = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("T5 valid after reset", 32'(m_tvalid), 32'd0);
        check("T5 ready after reset", 32'(s_tready), 32'd1);
        check("T5 data after reset", 32'(m_tdata), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("T5 flushed cycle%0d", c), 32'(m_tvalid), 32'd0);
        end
        check("T5 no flushed output", 32'(outq.size()), 32'd0);
        outq.delete();
        expq.push_back(pk(2, -8));
        send(2, 0);
        s_tvalid = 1'b0;
        wait_drain("T5");

        // Config update timing. Fold is now 1.
        expq.push_back(pk(0, 0));
        send(0, 0);
        s_tvalid = 1'b0;
        cfg_write(0, 10, -20, 0, 0);
        expq.push_back(pk(0, 0));
        send(2, 0);
        s_tvalid = 1'b0;
        expq.push_back(pk(0, 0));
        send(0, 0);
        s_tvalid  = 1'b0;
        // Write and nf0 read on the same edge: old scale (0) applies.
        s_tvalid  = 1'b1;
        s_tdata   = {17'(0), 17'(2)};
        cfg_we    = 1'b1;
        cfg_addr  = 1'b0;
        cfg_bias  = {17'(-20), 17'(10)};
        cfg_scale = {8'(200), 8'(3)};
        @(negedge clk);
        check("T6 same-cycle ready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        cfg_we   = 1'b0;
        expq.push_back(pk(0, 0));
        expq.push_back(pk(0, 0));
        send(0, 0);
        expq.push_back(pk(2, -8));
        send(2, 0);
        s_tvalid = 1'b0;
        wait_drain("T6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvu_requant_axi.md
Name: mvu_requant_axi

Overview:
- Streaming requantization stage placed directly downstream of the MVU/VVU AXI wrapper.
- Consumes one beat per channel fold. Each beat carries PE signed accumulators.
- Per output channel it computes y = clip(round(((acc + bias[c]) * scale[c]) >> SHIFT)) and emits PE narrow activations for the next layer.
- Per-channel bias/scale live in an internal parameter memory, written through a simple config port.

Parameters:
- PE, 1, accumulator lanes per beat; must match the upstream MVU/VVU.
- MH, 4, output channels; MH%PE == 0; NF = MH/PE.
- ACCU_WIDTH, 17, signed accumulator width per lane.
- SCALE_WIDTH, 8, unsigned per-channel scale width.
- SHIFT, 4, right shift after scaling; SHIFT == 0 means no rounding.
- OUTPUT_WIDTH, 4, per-lane output width.
- SIGNED_OUTPUTS, 1, 1 = signed clip range, 0 = unsigned clip range.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  parameter word write enable.
- cfg_addr  in  $clog2(NF) (min 1)  fold index nf to write.
- cfg_bias  in  PE*ACCU_WIDTH  signed bias; lane p is bits [p*ACCU_WIDTH +: ACCU_WIDTH].
- cfg_scale  in  PE*SCALE_WIDTH  unsigned scales, same lane order.
- s_axis_tdata  in  PE*ACCU_WIDTH  accumulators, lane p = channel nf*PE+p.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  PE*OUTPUT_WIDTH  requantized lanes.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high.
  - Outputs after reset: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0.
  - Reset clears all stage valids and the fold counter (nf=0).
  - Parameter memory is NOT reset; its contents are retained.
  - Reset asserted mid-stream flushes in-flight beats with no output; the next accepted beat is treated as nf=0.
- Pipeline: three stages with a global enable en = !m_axis_tvalid || m_axis_tready.
  - s_axis_tready = en.
  - Latency is 3 cycles from input handshake to m_axis_tvalid when there is no backpressure.
  - Throughput is 1 beat/cycle.
  - When en=0 all stages hold and m_axis_tdata is stable while valid.
  - No beat is dropped or duplicated.
- Fold counter: nf increments on each input handshake and wraps NF-1 -> 0. For NF=1 it stays 0.
- S1: register acc and the param word at nf; compute sum = acc + bias, sign-extended to ACCU_WIDTH+1.
- S2: prod = sum * $signed({1'b0, scale}), full width ACCU_WIDTH+SCALE_WIDTH+2.
- S3:
  - If SHIFT > 0: r = (prod + 2^(SHIFT-1)) >>> SHIFT. This is round-half-up, arithmetic shift.
  - Clip r to [-2^(OW-1), 2^(OW-1)-1] when signed, or [0, 2^OW-1] when unsigned, then register.
- Config writes:
  - Write the full PE-wide word at cfg_addr on a cfg_we cycle.
  - A write becomes visible to S1 reads from the following cycle. A same-cycle read of the same address returns the old word.
  - cfg_addr >= NF is ignored.
- Simultaneous input and output handshake in the same cycle: both complete and the pipeline advances.

Test Plan:
Configuration for all scenarios: PE=2, MH=4 (NF=2), ACCU_WIDTH=17, SCALE_WIDTH=8, SHIFT=4, OW=4, signed.
1. Identity and clip: bias=0, scale=16 for all channels; feed acc lanes (5,-3), (100,-100) -> outputs (5,-3), (7,-8). m_axis_tvalid first rises 3 cycles after the first handshake.
2. Rounding: scale=1, bias=0; acc (8,7) -> (1,0); acc (-8,-9) -> (0,-1).
3. Per-fold params and wrap: nf0 bias=(-3,0) scale=16; nf1 bias=(0,0) scale=(32,0).
   - Feed 6 beats, each lane acc=3.
   - Expected outputs: (0,3), (6,0), (0,3), (6,0), (0,3), (6,0).
   - Confirms nf wraps 1 -> 0.
4. Backpressure: 8 random beats with m_axis_tready held low for cycles 5-14.
   - s_axis_tready must be low whenever m_axis_tvalid && !m_axis_tready.
   - All 8 outputs match the golden model, in order.
   - m_axis_tdata is stable during the stall.
5. Reset mid-stream: accept 3 beats, assert rst for 1 cycle.
   - m_axis_tvalid=0 the next cycle.
   - The next input uses nf0 params.
   - Params written before reset are still in effect.
6. Config update between beats: write nf0 scale=0 one cycle before a beat arrives -> that beat outputs (0,0). A write in the same cycle as S1 reads nf0 -> the old scale is used.
